// File: rtl/pmodclp_write_seq.sv
// PmodCLP (HD44780-class) write sequencer: power-up init, then one byte per
// valid/ready handshake, driven out with setup/pulse/hold/execution timing.
module pmodclp_write_seq #(
    parameter int unsigned T_PWRUP = 2_000_000,
    parameter int unsigned T_AS    = 4,
    parameter int unsigned T_PW    = 25,
    parameter int unsigned T_H     = 2,
    parameter int unsigned T_EXEC  = 4_000,
    parameter int unsigned T_LONG  = 164_000
) (
    input  logic       sysclk,
    input  logic       sysreset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] lcd_d,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    localparam int unsigned CNT_W = 22;

    // Last count value of each timed state (counter runs 0 .. N-1).
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] AS_LAST    = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] PW_LAST    = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(T_H - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(T_LONG - 1);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT_ISSUE,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       init_idx;
    logic [1:0]       init_idx_next;
    logic [7:0]       lcd_d_next;
    logic             lcd_rs_next;
    logic             lcd_e_next;
    logic             req_ready_next;
    logic             init_done_next;
    logic             busy_next;
    logic             is_long;
    logic [CNT_W-1:0] exec_last;

    // Init command ROM: 8-bit/2-line, display on, clear, entry mode.
    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    init_rom = 8'h38;
            2'd1:    init_rom = 8'h0C;
            2'd2:    init_rom = 8'h01;
            default: init_rom = 8'h06;
        endcase
    endfunction

    // Clear (0x01) and Home (0x02/0x03) need the long execution wait.
    always_comb begin
        is_long   = !lcd_rs && (lcd_d[7:2] == 6'd0) && (lcd_d != 8'd0);
        exec_last = is_long ? LONG_LAST : EXEC_LAST;
    end

    // Next-state, counter and next output values.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt + CNT_W'(1);
        init_idx_next  = init_idx;
        lcd_d_next     = lcd_d;
        lcd_rs_next    = lcd_rs;
        init_done_next = init_done;

        case (state)
            S_PWRUP: begin
                if (cnt == PWRUP_LAST) begin
                    state_next    = S_INIT_ISSUE;
                    cnt_next      = '0;
                    init_idx_next = 2'd0;
                end
            end
            S_INIT_ISSUE: begin
                state_next  = S_SETUP;
                cnt_next    = '0;
                lcd_d_next  = init_rom(init_idx);
                lcd_rs_next = 1'b0;
            end
            S_IDLE: begin
                cnt_next = '0;
                if (req_valid && req_ready) begin
                    state_next  = S_SETUP;
                    lcd_d_next  = req_data;
                    lcd_rs_next = req_rs;
                end
            end
            S_SETUP: begin
                if (cnt == AS_LAST) begin
                    state_next = S_PULSE;
                    cnt_next   = '0;
                end
            end
            S_PULSE: begin
                if (cnt == PW_LAST) begin
                    state_next = S_HOLD;
                    cnt_next   = '0;
                end
            end
            S_HOLD: begin
                if (cnt == H_LAST) begin
                    state_next = S_EXEC;
                    cnt_next   = '0;
                end
            end
            S_EXEC: begin
                if (cnt == exec_last) begin
                    cnt_next = '0;
                    if (init_done) begin
                        state_next = S_IDLE;
                    end else if (init_idx == 2'd3) begin
                        state_next     = S_IDLE;
                        init_done_next = 1'b1;
                    end else begin
                        state_next    = S_INIT_ISSUE;
                        init_idx_next = init_idx + 2'd1;
                    end
                end
            end
            default: begin
                state_next = S_PWRUP;
                cnt_next   = '0;
            end
        endcase

        lcd_e_next     = (state_next == S_PULSE);
        req_ready_next = (state_next == S_IDLE);
        busy_next      = (state_next != S_IDLE);
    end

    // State, counter and registered outputs; reset restarts the init sequence.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state     <= S_PWRUP;
            cnt       <= '0;
            init_idx  <= 2'd0;
            lcd_d     <= 8'h00;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_e     <= 1'b0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            init_idx  <= init_idx_next;
            lcd_d     <= lcd_d_next;
            lcd_rs    <= lcd_rs_next;
            lcd_rw    <= 1'b0;
            lcd_e     <= lcd_e_next;
            req_ready <= req_ready_next;
            init_done <= init_done_next;
            busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_pmodclp_write_seq.sv
// Scoreboard bench for pmodclp_write_seq: the stimulus pushes expected LCD
// writes, a negedge monitor pops and checks each lcd_e strobe and its timing.
module tb_pmodclp_write_seq;

    localparam int unsigned P_PWRUP = 20;
    localparam int unsigned P_AS    = 2;
    localparam int unsigned P_PW    = 5;
    localparam int unsigned P_H     = 1;
    localparam int unsigned P_EXEC  = 10;
    localparam int unsigned P_LONG  = 40;

    logic       sysclk = 1'b0;
    logic       sysreset;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       init_done;
    logic       busy;
    logic [7:0] lcd_d;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;

    pmodclp_write_seq #(
        .T_PWRUP (P_PWRUP),
        .T_AS    (P_AS),
        .T_PW    (P_PW),
        .T_H     (P_H),
        .T_EXEC  (P_EXEC),
        .T_LONG  (P_LONG)
    ) dut (
        .sysclk    (sysclk),
        .sysreset  (sysreset),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .init_done (init_done),
        .busy      (busy),
        .lcd_d     (lcd_d),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e)
    );

    always #5 sysclk = ~sysclk;

    // lead: cycles from reference (release, accept or previous fall) to lcd_e rise
    // tail: cycles from lcd_e fall to req_ready rise (-1 = not checked)
    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         lead;
        int         tail;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic rs, input int lead, input int tail);
        exp_t e;
        e.data = d;
        e.rs   = rs;
        e.lead = lead;
        e.tail = tail;
        exp_q.push_back(e);
    endtask

    // Monitor state
    int         cyc = 0;
    int         ref_cyc = 0;
    int         fall_cyc = 0;
    int         width = 0;
    int         tail_exp = 0;
    bit         rst_seen = 0;
    bit         in_pulse = 0;
    bit         tail_pend = 0;
    bit         d_chk = 0;
    bit         stable_bad = 0;
    logic       prev_ready = 1'b0;
    logic [7:0] pulse_d;
    logic       pulse_rs;
    exp_t       cur;
    exp_t       acc;

    // Monitor: pops one expectation per lcd_e strobe and checks its timing.
    always @(negedge sysclk) begin
        cyc++;
        check("lcd_rw_low", int'(lcd_rw), 0);
        if (sysreset) begin
            rst_seen  = 1;
            in_pulse  = 0;
            tail_pend = 0;
            d_chk     = 0;
        end else begin
            if (rst_seen) begin
                rst_seen = 0;
                ref_cyc  = cyc;
            end
            if (d_chk) begin
                d_chk = 0;
                check("latched_d", int'(lcd_d), int'(acc.data));
                check("latched_rs", int'(lcd_rs), int'(acc.rs));
            end
            if (in_pulse) begin
                if (lcd_d !== pulse_d || lcd_rs !== pulse_rs) stable_bad = 1;
                if (lcd_e) begin
                    width++;
                end else begin
                    check("pulse_width", width, int'(P_PW));
                    check("bus_stable", int'(stable_bad), 0);
                    in_pulse = 0;
                    ref_cyc  = cyc;
                    fall_cyc = cyc;
                    if (cur.tail >= 0) begin
                        tail_pend = 1;
                        tail_exp  = cur.tail;
                    end
                end
            end else if (lcd_e) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: lcd_d=0x%0h with no expected write at %0t", lcd_d, $time);
                    cur.data = lcd_d;
                    cur.rs   = lcd_rs;
                    cur.lead = 0;
                    cur.tail = -1;
                end else begin
                    cur = exp_q.pop_front();
                    check("rise_lead", cyc - ref_cyc, cur.lead);
                    check("pulse_d", int'(lcd_d), int'(cur.data));
                    check("pulse_rs", int'(lcd_rs), int'(cur.rs));
                end
                in_pulse   = 1;
                width      = 1;
                pulse_d    = lcd_d;
                pulse_rs   = lcd_rs;
                stable_bad = 0;
            end
            if (req_ready && !prev_ready && tail_pend) begin
                check("ready_tail", cyc - fall_cyc, tail_exp);
                tail_pend = 0;
            end
            if (req_valid && req_ready) begin
                ref_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_accept: data=0x%0h with no expected write at %0t", req_data, $time);
                end else begin
                    acc   = exp_q[0];
                    d_chk = 1;
                end
            end
        end
        prev_ready = req_ready;
    end

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge sysclk);
            n++;
        end while (!(req_ready && exp_q.size() == 0 && !tail_pend) && n < 3000);
        if (n >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: ready=%0d queued=%0d, expected idle within 3000 cycles", name, req_ready, exp_q.size());
        end
    endtask

    task automatic send(input logic [7:0] d, input logic rs);
        int n = 0;
        @(posedge sysclk); #1;
        req_valid = 1'b1;
        req_data  = d;
        req_rs    = rs;
        do begin
            @(negedge sysclk);
            n++;
        end while (!req_ready && n < 3000);
        if (n >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: ready=0, expected accept of 0x%0h", d);
        end
        @(posedge sysclk); #1;
        req_valid = 1'b0;
    endtask

    task automatic reset_and_init(input string name);
        push_exp(8'h38, 1'b0, 23, -1);
        push_exp(8'h0C, 1'b0, 14, -1);
        push_exp(8'h01, 1'b0, 14, -1);
        push_exp(8'h06, 1'b0, 44, 11);
        sysreset = 1'b0;
        wait_idle(name);
        check({name, "_init_done"}, int'(init_done), 1);
        check({name, "_busy_idle"}, int'(busy), 0);
    endtask

    initial begin
        int n;
        sysreset  = 1'b1;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'h00;

        // Scenario 1: reset state, then power-up init sequence
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_lcd_d", int'(lcd_d), 0);
        check("rst_lcd_rs", int'(lcd_rs), 0);
        check("rst_lcd_e", int'(lcd_e), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_busy", int'(busy), 1);
        reset_and_init("init1");

        // Scenarios 2-3: single writes, normal vs long execution
        push_exp(8'h41, 1'b1, 3, 11); send(8'h41, 1'b1); wait_idle("data41");
        push_exp(8'h01, 1'b0, 3, 41); send(8'h01, 1'b0); wait_idle("clear");
        push_exp(8'h80, 1'b0, 3, 11); send(8'h80, 1'b0); wait_idle("ddram");
        push_exp(8'h02, 1'b0, 3, 41); send(8'h02, 1'b0); wait_idle("home");
        push_exp(8'h04, 1'b0, 3, 11); send(8'h04, 1'b0); wait_idle("entry04");
        push_exp(8'h00, 1'b0, 3, 11); send(8'h00, 1'b0); wait_idle("zero_cmd");
        push_exp(8'h01, 1'b1, 3, 11); send(8'h01, 1'b1); wait_idle("data01");

        // Scenario 4: valid held high across two bytes
        push_exp(8'h41, 1'b1, 3, 11);
        push_exp(8'h42, 1'b1, 3, 11);
        @(posedge sysclk); #1;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h41;
        n = 0;
        do begin @(negedge sysclk); n++; end while (!req_ready && n < 100);
        @(posedge sysclk); #1;
        req_data = 8'h42;
        n = 0;
        do begin @(negedge sysclk); n++; end while (!req_ready && n < 100);
        check("b2b_accept_gap", n, 19);
        @(posedge sysclk); #1;
        req_valid = 1'b0;
        wait_idle("b2b");

        // Scenario 5: reset during PULSE, then full re-init
        push_exp(8'h43, 1'b1, 3, -1);
        send(8'h43, 1'b1);
        n = 0;
        do begin @(negedge sysclk); n++; end while (!lcd_e && n < 100);
        check("pulse_seen_before_reset", int'(lcd_e), 1);
        @(posedge sysclk); #1;
        sysreset = 1'b1;
        @(posedge sysclk); #1;
        check("midrst_lcd_e", int'(lcd_e), 0);
        check("midrst_init_done", int'(init_done), 0);
        check("midrst_req_ready", int'(req_ready), 0);
        check("midrst_busy", int'(busy), 1);
        check("midrst_lcd_d", int'(lcd_d), 0);
        repeat (2) @(posedge sysclk);
        #1;
        reset_and_init("init2");

        push_exp(8'h44, 1'b1, 3, 11); send(8'h44, 1'b1); wait_idle("post_reinit");
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
